// File: rtl/shift_pkg.sv
// Shared types and constants for the shift execution unit.
// Rotate support is compiled in when SHIFT_EXEC_ROTATE_EN is defined.
package shift_pkg;

    localparam int SHIFT_W = 32;
    localparam int AMT_W   = 5;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b100,
        OP_ROR = 3'b101
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PASS2 = 2'b01,
        DONE  = 2'b10
    } shift_state_e;

    function automatic logic op_is_rotate(input logic [2:0] op);
`ifdef SHIFT_EXEC_ROTATE_EN
        return (op == OP_ROL) || (op == OP_ROR);
`else
        return (op != op);
`endif
    endfunction

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || op_is_rotate(op);
    endfunction

endpackage

// File: rtl/BitShiftLeft.sv
// Left shifter whose vacated low bits are filled with a selectable fill bit
// (fill=1 after operand reversal gives arithmetic right shift).
module BitShiftLeft
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0] data,
    input  logic [AMT_W-1:0]   amount,
    input  logic               fill,
    output logic [SHIFT_W-1:0] result
);

    logic [SHIFT_W-1:0] fill_mask;

    assign fill_mask = ~({SHIFT_W{1'b1}} << amount);
    assign result    = (data << amount) | (fill_mask & {SHIFT_W{fill}});

endmodule

// File: rtl/shift_operand_reverser.sv
// Combinational 32-bit bit-reversal with bypass; used on both sides of the
// left shifter so that right shifts reuse the same hardware.
module shift_operand_reverser
    import shift_pkg::*;
(
    input  logic [SHIFT_W-1:0] data,
    input  logic               enable,
    output logic [SHIFT_W-1:0] result
);

    logic [SHIFT_W-1:0] flipped;

    genvar gi;
    generate
        for (gi = 0; gi < SHIFT_W; gi++) begin : g_rev
            assign flipped[gi] = data[SHIFT_W-1-gi];
        end
    endgenerate

    assign result = enable ? flipped : data;

endmodule

// File: rtl/shift_exec_unit.sv
// Execute-stage shift unit: valid/ready request in, registered result out.
// Define SHIFT_EXEC_ROTATE_EN to add two-pass ROL/ROR; otherwise they are illegal.
module shift_exec_unit
    import shift_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [SHIFT_W-1:0] in_operand,
    input  logic [AMT_W-1:0]   in_amount,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SHIFT_W-1:0] out_result,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_illegal
);

    shift_state_e       state_reg, state_next;
    logic               accept, op_rotate, op_legal;
    logic [SHIFT_W-1:0] result_reg;
    logic [TAG_W-1:0]   tag_reg;
    logic               illegal_reg;

    logic [SHIFT_W-1:0] sh_data, sh_pre, sh_raw, sh_result;
    logic [AMT_W-1:0]   sh_amount;
    logic               sh_fill, sh_reverse;

`ifdef SHIFT_EXEC_ROTATE_EN
    logic [SHIFT_W-1:0] partial_reg, operand_reg;
    logic [AMT_W-1:0]   rot_amt_reg;
`endif

    assign op_rotate = op_is_rotate(in_op);
    assign op_legal  = op_is_legal(in_op);
    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign out_valid = (state_reg == DONE);
    assign accept    = in_valid && in_ready;

    // Shared shifter control: the second rotate pass is a logical right shift
    // of the saved operand by the complement of the stored left amount.
    always_comb begin
        sh_data    = in_operand;
        sh_amount  = in_amount;
        sh_fill    = 1'b0;
        sh_reverse = 1'b0;
        case (in_op)
            OP_SRL: sh_reverse = 1'b1;
            OP_SRA: begin
                sh_reverse = 1'b1;
                sh_fill    = in_operand[SHIFT_W-1];
            end
            OP_ROR:  sh_amount = AMT_W'(0) - in_amount;
            default: ;
        endcase
`ifdef SHIFT_EXEC_ROTATE_EN
        if (state_reg == PASS2) begin
            sh_data    = operand_reg;
            sh_amount  = AMT_W'(0) - rot_amt_reg;
            sh_fill    = 1'b0;
            sh_reverse = 1'b1;
        end
`endif
    end

    shift_operand_reverser u_pre_rev (
        .data   (sh_data),
        .enable (sh_reverse),
        .result (sh_pre)
    );

    BitShiftLeft u_shift (
        .data   (sh_pre),
        .amount (sh_amount),
        .fill   (sh_fill),
        .result (sh_raw)
    );

    shift_operand_reverser u_post_rev (
        .data   (sh_raw),
        .enable (sh_reverse),
        .result (sh_result)
    );

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) state_next = op_rotate ? PASS2 : DONE;
            end
            DONE: begin
                if (accept)         state_next = op_rotate ? PASS2 : DONE;
                else if (out_ready) state_next = IDLE;
            end
            PASS2:   state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg  <= '0;
            tag_reg     <= '0;
            illegal_reg <= 1'b0;
`ifdef SHIFT_EXEC_ROTATE_EN
            partial_reg <= '0;
            operand_reg <= '0;
            rot_amt_reg <= '0;
`endif
        end else if (accept) begin
            tag_reg     <= in_tag;
            illegal_reg <= !op_legal;
            if (!op_legal)       result_reg <= in_operand;
            else if (!op_rotate) result_reg <= sh_result;
`ifdef SHIFT_EXEC_ROTATE_EN
            partial_reg <= sh_result;
            operand_reg <= in_operand;
            rot_amt_reg <= sh_amount;
        end else if (state_reg == PASS2) begin
            result_reg <= partial_reg | sh_result;
`endif
        end
    end

    assign out_result  = result_reg;
    assign out_tag     = tag_reg;
    assign out_illegal = illegal_reg;

endmodule

// File: tb/tb_shift_exec_unit.sv
// Scoreboard bench for shift_exec_unit; rotate scenarios compile in when
// SHIFT_EXEC_ROTATE_EN is defined.
module tb_shift_exec_unit;

    localparam int TAG_W = 4;
`ifdef SHIFT_EXEC_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        in_op = '0;
    logic [31:0]       in_operand = '0;
    logic [4:0]        in_amount = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_result;
    logic [TAG_W-1:0]  out_tag;
    logic              out_illegal;

    typedef struct {
        logic [31:0]      result;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    shift_exec_unit #(.TAG_W(TAG_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_operand  (in_operand),
        .in_amount   (in_amount),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [4:0] n, input logic [TAG_W-1:0] tag);
        exp_t        e;
        logic [63:0] dbl;
        dbl       = {a, a};
        e.tag     = tag;
        e.illegal = 1'b0;
        e.result  = a;
        case (op)
            3'b000: e.result = a << n;
            3'b001: e.result = a >> n;
            3'b010: e.result = $signed(a) >>> n;
            3'b100: if (ROT_EN) begin dbl = dbl << n; e.result = dbl[63:32]; end
                    else e.illegal = 1'b1;
            3'b101: if (ROT_EN) begin dbl = dbl >> n; e.result = dbl[31:0]; end
                    else e.illegal = 1'b1;
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    // Scoreboard monitor: a result is consumed at the edge following this sample.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got result=%08h tag=%0h expected no output", out_result, out_tag);
            end else begin
                mon_e = sb.pop_front();
                if (out_result !== mon_e.result || out_tag !== mon_e.tag || out_illegal !== mon_e.illegal) begin
                    errors++;
                    $display("FAIL sb_result got result=%08h tag=%0h illegal=%0b expected result=%08h tag=%0h illegal=%0b",
                             out_result, out_tag, out_illegal, mon_e.result, mon_e.tag, mon_e.illegal);
                end else begin
                    $display("txn tag=%0h result=%08h illegal=%0b", out_tag, out_result, out_illegal);
                end
            end
        end
    end

    // Presents a request and returns at posedge+1 after it has been accepted.
    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [4:0] n,
                         input logic [TAG_W-1:0] tag, input bit push, output int waits);
        in_valid   = 1'b1;
        in_op      = op;
        in_operand = a;
        in_amount  = n;
        in_tag     = tag;
        if (push) sb.push_back(model(op, a, n, tag));
        waits = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout got in_ready=%b expected 1 within 50 cycles", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks += 5;
        if (out_valid !== 1'b0)    begin errors++; $display("FAIL rst_valid got %b expected 0", out_valid); end
        if (in_ready !== 1'b1)     begin errors++; $display("FAIL rst_ready got %b expected 1", in_ready); end
        if (out_result !== 32'h0)  begin errors++; $display("FAIL rst_result got %08h expected 0", out_result); end
        if (out_tag !== '0)        begin errors++; $display("FAIL rst_tag got %0h expected 0", out_tag); end
        if (out_illegal !== 1'b0)  begin errors++; $display("FAIL rst_illegal got %b expected 0", out_illegal); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sll();
        int w;
        out_ready = 1'b1;
        drive(3'b000, 32'h0000_0001, 5'd31, 4'h1, 1'b1, w);
        in_valid = 1'b0;
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL sll_latency got out_valid=%b expected 1", out_valid); end
        if (out_result !== 32'h8000_0000) begin errors++; $display("FAIL sll_result got %08h expected 80000000", out_result); end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL sll_idle got out_valid=%b expected 0", out_valid); end
        wait_drain();
    endtask

    task automatic test_right_shifts();
        int w;
        out_ready = 1'b1;
        drive(3'b010, 32'h8000_0000, 5'd4, 4'h2, 1'b1, w);
        drive(3'b001, 32'h8000_0000, 5'd4, 4'h3, 1'b1, w);
        drive(3'b010, 32'h8000_0000, 5'd0, 4'h4, 1'b1, w);
        drive(3'b001, 32'hDEAD_BEEF, 5'd0, 4'h5, 1'b1, w);
        drive(3'b000, 32'hDEAD_BEEF, 5'd0, 4'h6, 1'b1, w);
        drive(3'b010, 32'h7FFF_FFFF, 5'd31, 4'h7, 1'b1, w);
        in_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_stall();
        int w;
        out_ready = 1'b0;
        drive(3'b000, 32'h0000_00F0, 5'd4, 4'h5, 1'b1, w);
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks += 4;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b expected 1", out_valid); end
            if (out_result !== 32'h0000_0F00) begin errors++; $display("FAIL stall_result got %08h expected 00000f00", out_result); end
            if (out_tag !== 4'h5) begin errors++; $display("FAIL stall_tag got %0h expected 5", out_tag); end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b expected 0", in_ready); end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive(3'b001, 32'h0000_0100, 5'd8, 4'h6, 1'b1, w);
        in_valid = 1'b0;
        checks += 2;
        if (w != 0) begin errors++; $display("FAIL stall_same_edge got waits=%0d expected 0", w); end
        if (out_valid !== 1'b1 || out_tag !== 4'h6) begin
            errors++;
            $display("FAIL stall_next got valid=%b tag=%0h expected valid=1 tag=6", out_valid, out_tag);
        end
        wait_drain();
    endtask

    task automatic test_illegal();
        int w;
        out_ready = 1'b1;
        drive(3'b011, 32'h1234_5678, 5'd7, 4'h9, 1'b1, w);
        in_valid = 1'b0;
        checks += 3;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL ill_latency got out_valid=%b expected 1", out_valid); end
        if (out_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %b expected 1", out_illegal); end
        if (out_result !== 32'h1234_5678) begin errors++; $display("FAIL ill_result got %08h expected 12345678", out_result); end
        drive(3'b110, 32'hCAFE_F00D, 5'd3, 4'hA, 1'b1, w);
        drive(3'b111, 32'h0BAD_CAFE, 5'd9, 4'hB, 1'b1, w);
        drive(3'b000, 32'h0000_0003, 5'd2, 4'hC, 1'b1, w);
        in_valid = 1'b0;
        wait_drain();
`ifndef SHIFT_EXEC_ROTATE_EN
        drive(3'b100, 32'h1234_5678, 5'd1, 4'hD, 1'b1, w);
        in_valid = 1'b0;
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rol_off_latency got out_valid=%b expected 1", out_valid); end
        if (out_illegal !== 1'b1) begin errors++; $display("FAIL rol_off_flag got %b expected 1", out_illegal); end
        drive(3'b101, 32'h8765_4321, 5'd5, 4'hE, 1'b1, w);
        in_valid = 1'b0;
        wait_drain();
`endif
    endtask

`ifdef SHIFT_EXEC_ROTATE_EN
    task automatic test_rotate();
        int w;
        out_ready = 1'b1;
        drive(3'b100, 32'h8000_0001, 5'd1, 4'hA, 1'b1, w);
        in_valid = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rot_pass2_valid got %b expected 0", out_valid); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rot_pass2_ready got %b expected 0", in_ready); end
        @(posedge clk);
        #1;
        checks += 2;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rot_latency got out_valid=%b expected 1", out_valid); end
        if (out_result !== 32'h0000_0003) begin errors++; $display("FAIL rol_result got %08h expected 00000003", out_result); end
        wait_drain();
        drive(3'b101, 32'h0000_0003, 5'd1, 4'hB, 1'b1, w);
        drive(3'b100, 32'h1234_5678, 5'd0, 4'hC, 1'b1, w);
        drive(3'b101, 32'h1234_5678, 5'd0, 4'hD, 1'b1, w);
        for (int i = 0; i < 6; i++)
            drive(3'($urandom_range(4, 5)), $urandom, 5'($urandom_range(0, 31)), 4'(i), 1'b1, w);
        in_valid = 1'b0;
        wait_drain();
    endtask
`endif

    task automatic test_back_to_back();
        int w;
        int total_waits = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(3'($urandom_range(0, 2)), $urandom, 5'($urandom_range(0, 31)), 4'(i), 1'b1, w);
            total_waits += w;
        end
        in_valid = 1'b0;
        checks++;
        if (total_waits != 0) begin errors++; $display("FAIL b2b_rate got stall_cycles=%0d expected 0", total_waits); end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int w;
        bit seen = 1'b0;
        out_ready = 1'b0;
        drive(3'b000, 32'h0000_00FF, 5'd4, 4'h3, 1'b0, w);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_done_valid got %b expected 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_done_ready got %b expected 1", in_ready); end
        if (out_result !== 32'h0) begin errors++; $display("FAIL rst_done_result got %08h expected 0", out_result); end
`ifdef SHIFT_EXEC_ROTATE_EN
        out_ready = 1'b1;
        drive(3'b100, 32'hF000_000F, 5'd4, 4'h8, 1'b0, w);
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_pass2_valid got %b expected 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_pass2_ready got %b expected 1", in_ready); end
        if (out_result !== 32'h0) begin errors++; $display("FAIL rst_pass2_result got %08h expected 0", out_result); end
`endif
        repeat (5) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL rst_stale got out_valid pulse expected none"); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_sll();
        test_right_shifts();
        test_stall();
        test_illegal();
`ifdef SHIFT_EXEC_ROTATE_EN
        test_rotate();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
